// File: rtl/pet_ce_reset_gen_pkg.sv
// Shared types and constants for the PET clock-enable and reset sequencer.
package pet_ce_reset_gen_pkg;

    typedef enum logic [1:0] {
        RS_INIT = 2'd0,
        RS_HOLD = 2'd1,
        RS_RUN  = 2'd2
    } rs_state_t;

    // CPU period-1 values for a 112 MHz system clock
    localparam int RATE_1MHZ  = 111;
    localparam int RATE_TURBO = 30;

endpackage

// File: rtl/pet_ce_reset_gen_if.sv
// Control inputs and enable/reset outputs of the PET clock-enable and reset sequencer.
interface pet_ce_reset_gen_if #(
    parameter int NPIX   = 2,
    parameter int RATE_W = 7
);
    logic              pll_locked;
    logic              rst_req;
    logic              turbo;
    logic              cpu_stop;
    logic [RATE_W-1:0] rate_norm;
    logic [RATE_W-1:0] rate_turbo;
    logic [NPIX-1:0]   ce_pix;
    logic [NPIX-1:0]   ce_pixn;
    logic              ce_cpu;
    logic              turbo_active;
    logic              sys_reset;

    modport master (
        output pll_locked, rst_req, turbo, cpu_stop, rate_norm, rate_turbo,
        input  ce_pix, ce_pixn, ce_cpu, turbo_active, sys_reset
    );

    modport slave (
        input  pll_locked, rst_req, turbo, cpu_stop, rate_norm, rate_turbo,
        output ce_pix, ce_pixn, ce_cpu, turbo_active, sys_reset
    );
endinterface

// File: rtl/pet_ce_reset_gen_divider.sv
// Programmable CPU enable divider; the rate select is latched only at the period wrap.
module pet_ce_divider #(
    parameter int RATE_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stop_i,
    input  logic              turbo_i,
    input  logic [RATE_W-1:0] rate_norm_i,
    input  logic [RATE_W-1:0] rate_turbo_i,
    output logic              ce_o,
    output logic              turbo_active_o
);
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [RATE_W-1:0] cur_rate_q, cur_rate_d;
    logic              turbo_q, turbo_d;
    logic              ce_q;
    logic              wrap;

    assign wrap = (cnt_q == cur_rate_q);

    // cur_rate resets to 0 so the first cycle wraps and picks up the live rate
    always_comb begin
        cnt_d      = cnt_q;
        cur_rate_d = cur_rate_q;
        turbo_d    = turbo_q;
        if (!stop_i) begin
            if (wrap) begin
                cnt_d      = '0;
                cur_rate_d = turbo_i ? rate_turbo_i : rate_norm_i;
                turbo_d    = turbo_i;
            end else begin
                cnt_d = cnt_q + RATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            cur_rate_q <= '0;
            turbo_q    <= 1'b0;
            ce_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cur_rate_q <= cur_rate_d;
            turbo_q    <= turbo_d;
            ce_q       <= (cnt_q == '0) && !stop_i;
        end
    end

    assign ce_o           = ce_q;
    assign turbo_active_o = turbo_q;
endmodule

// File: rtl/pet_ce_reset_gen.sv
// Pixel enable ladder, CPU enable divider and power-on/user reset sequencer on one clock.
//   state   | meaning
//   RS_INIT | power-on hold, counting INIT_CYCLES
//   RS_HOLD | waiting for HOLD_CYCLES clean cycles (no request, PLL locked)
//   RS_RUN  | system out of reset
module pet_ce_reset_gen
    import pet_ce_reset_gen_pkg::*;
#(
    parameter int NPIX        = 2,
    parameter int RATE_W      = 7,
    parameter int INIT_CYCLES = 100_000_000,
    parameter int HOLD_CYCLES = 15
) (
    input logic               clk_i,
    input logic               rst_n_i,
    pet_ce_reset_gen_if.slave bus
);
    localparam int DIV_W  = NPIX + 3;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [DIV_W-1:0]  div_q;
    logic [NPIX-1:0]   ce_pix_q, ce_pix_d;
    logic [NPIX-1:0]   ce_pixn_q, ce_pixn_d;
    logic [1:0]        req_sync_q, lock_sync_q;
    logic              clean;
    rs_state_t         state_q;
    logic [INIT_W-1:0] init_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              sys_reset_q;

    for (genvar k = 0; k < NPIX; k++) begin : g_stage
        assign ce_pix_d[k]  = (div_q[k+2:0] == '0);
        assign ce_pixn_d[k] = div_q[k+2] && (div_q[k+1:0] == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q       <= '0;
            ce_pix_q    <= '0;
            ce_pixn_q   <= '0;
            req_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            div_q       <= div_q + DIV_W'(1);
            ce_pix_q    <= ce_pix_d;
            ce_pixn_q   <= ce_pixn_d;
            req_sync_q  <= {req_sync_q[0], bus.rst_req};
            lock_sync_q <= {lock_sync_q[0], bus.pll_locked};
        end
    end

    assign clean = !req_sync_q[1] && lock_sync_q[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RS_INIT;
            init_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            sys_reset_q <= 1'b1;
        end else begin
            case (state_q)
                RS_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_q    <= RS_HOLD;
                        hold_cnt_q <= '0;
                    end else begin
                        init_cnt_q <= init_cnt_q + INIT_W'(1);
                    end
                end
                RS_HOLD: begin
                    if (!clean) begin
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q     <= RS_RUN;
                        sys_reset_q <= 1'b0;
                        hold_cnt_q  <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                RS_RUN: begin
                    if (!clean) begin
                        state_q     <= RS_HOLD;
                        sys_reset_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end
                end
                default: begin
                    state_q     <= RS_INIT;
                    init_cnt_q  <= '0;
                    hold_cnt_q  <= '0;
                    sys_reset_q <= 1'b1;
                end
            endcase
        end
    end

    pet_ce_divider #(.RATE_W(RATE_W)) u_cpu_div (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .stop_i         (bus.cpu_stop),
        .turbo_i        (bus.turbo),
        .rate_norm_i    (bus.rate_norm),
        .rate_turbo_i   (bus.rate_turbo),
        .ce_o           (bus.ce_cpu),
        .turbo_active_o (bus.turbo_active)
    );

    assign bus.ce_pix    = ce_pix_q;
    assign bus.ce_pixn   = ce_pixn_q;
    assign bus.sys_reset = sys_reset_q;
endmodule
